mul_spi_master: RTL and testbench
=================================

// Module: mul_spi_master
// PURPOSE
//  Processor-side SPI master for the multiplier offload slave in the mini serial processor.
//  Latches two REGISTER_SIZE operands and shifts them out as a MulPacket ({op_2, op_1}, LSB first).
//  Waits for the slave's ready flag, then shifts in the REGISTER_SIZE product and returns it with a done pulse.
//  Sits between the processor execute stage and the Spi bus; SPI runs on the system clock (no separate sclk).
// PARAMETERS
//  NssWidth      4   width of spi.nss; one bit per slave on the bus
//  NssPosition   0   index of the nss bit that selects the multiplier slave
//  TimeoutCycles 64  max cycles spent in WAIT_RESULT before aborting with o_error
// PORTS
//  i_clock    in   1                 system clock; all logic on posedge
//  i_reset    in   1                 asynchronous, active-low reset
//  i_start    in   1                 request; sampled only in IDLE
//  i_op_1     in   REGISTER_SIZE     operand 1 (packet bits [R-1:0]); latched on accept
//  i_op_2     in   REGISTER_SIZE     operand 2 (packet bits [2R-1:R]); latched on accept
//  o_busy     out  1                 high in every state except IDLE
//  o_done     out  1                 one-cycle pulse, transaction finished
//  o_error    out  1                 valid with o_done; 1 = slave ack timeout
//  o_result   out  REGISTER_SIZE     product; holds until next accept
//  spi        Spi.MasterSpi          drives nss[NssWidth-1:0], mosi; samples miso
// BEHAVIOUR
//  Reset: IDLE; nss all 1; mosi=0; o_busy=0; o_done=0; o_error=0; o_result=0; counters=0.
//  R = REGISTER_SIZE; P = 2R (packet bits). nss[NssPosition] is low in every state except IDLE and DONE; other nss bits are always 1.
//  States:
//   IDLE: mosi=0. If i_start=1, latch {op_2,op_1} into a shift register, clear the bit counter -> START.
//   START: 1 cycle, mosi=1 (start flag; slave miso=0 here) -> SEND_BITS.
//   SEND_BITS: mosi=packet[cnt], cnt 0..P-1, one bit per cycle; after bit P-1 -> WAIT_RESULT, clear counters.
//   WAIT_RESULT: mosi=0 (required by slave ack condition). Only miso===1'b1 counts as ack (z/x/0 ignored).
//     Ack sampled at posedge -> RECV_BITS. If wait count reaches TimeoutCycles-1 without ack -> DONE with error.
//   RECV_BITS: mosi=0. At each posedge o_result shift reg [cnt] <= miso, cnt 0..R-1; after bit R-1 -> DONE.
//   DONE: 1 cycle; nss all 1; o_done=1; o_error per path -> IDLE.
//  Latency with a compliant slave (1 OPERATE cycle): accept edge = cycle 0 -> o_done in cycle 3R+4.
//  Error path: o_result forced to 0, o_error=1 for the DONE cycle only; o_error cleared on next accept.
//  i_start while busy: ignored, never queued. i_start in DONE: ignored (new accept earliest in IDLE).
//  Operands may change after accept without effect; o_result changes only in RECV_BITS.
//  Reset mid-transaction: immediate IDLE and nss release; partial result discarded (o_result=0).
//  Back-to-back: IDLE->START needs i_start high in IDLE, so min gap is one IDLE cycle after DONE.
//  Counters sized $clog2(max(P,TimeoutCycles))+1; no wrap inside a state.
//  Multiplication is done by the slave; the product is truncated to R bits by the slave, not re-checked here.
// TESTING
//  T1 R=8, op_1=3, op_2=5, behavioural slave -> mosi 1 then 0xC... bits LSB-first (0x0503); o_done cycle 28; o_result=15; o_error=0.
//  T2 op_1=0xFF, op_2=0xFF -> o_result=0x01 (truncated 0xFE01); nss[NssPosition] low cycles 1..27 only.
//  T3 slave never acks (miso=z), TimeoutCycles=64 -> o_done with o_error=1, o_result=0; nss released in DONE.
//  T4 i_start pulsed in SEND_BITS and DONE of op 2x3 -> ignored; single o_done; o_result=6; next start in IDLE accepted.
//  T5 i_reset low mid-RECV_BITS (bit 3) -> same cycle nss all 1, o_busy=0; after release, 7x6 returns 42.
//  T6 NssWidth=4, NssPosition=2 -> only nss[2] toggles; nss[0,1,3] stay 1 throughout.

Source files
------------

// File: rtl/mul_spi_master_if.sv
// Serial bus between the processor-side master and its offload slaves.
// One active-low select line per slave; data moves on the system clock.
interface Spi #(
  parameter int NssWidth = 4
);
  logic [NssWidth-1:0] nss;
  logic                mosi;
  logic                miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/mul_spi_master.sv
// SPI master for the multiplier offload slave: sends {op_2, op_1} LSB first,
// waits for the slave's ack, then shifts the truncated product back in.
module mul_spi_master #(
  parameter int REGISTER_SIZE = 8,
  parameter int NssWidth      = 4,
  parameter int NssPosition   = 0,
  parameter int TimeoutCycles = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [REGISTER_SIZE-1:0] i_op_1,
  input  logic [REGISTER_SIZE-1:0] i_op_2,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [REGISTER_SIZE-1:0] o_result,
  Spi.MasterSpi                    spi
);

  localparam int P      = 2 * REGISTER_SIZE;
  localparam int CntMax = (P > TimeoutCycles) ? P : TimeoutCycles;
  localparam int CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] LastSend = CntW'(P - 1);
  localparam logic [CntW-1:0] LastRecv = CntW'(REGISTER_SIZE - 1);
  localparam logic [CntW-1:0] LastWait = CntW'(TimeoutCycles - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]               r_state;
  logic [CntW-1:0]          r_cnt;
  logic [P-1:0]             r_pkt;
  logic [REGISTER_SIZE-1:0] r_result;
  logic                     r_error;

  logic                w_ack;
  logic                w_mosi;
  logic [NssWidth-1:0] w_nss;

  // A floating or unknown miso line must never be mistaken for an ack.
  assign w_ack = (spi.miso === 1'b1);

  always_comb begin
    w_mosi = 1'b0;
    case (r_state)
      S_START: w_mosi = 1'b1;
      S_SEND:  w_mosi = r_pkt[0];
      default: w_mosi = 1'b0;
    endcase
  end

  always_comb begin
    w_nss = '1;
    if (r_state != S_IDLE && r_state != S_DONE) w_nss[NssPosition] = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pkt    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_pkt   <= {i_op_2, i_op_1};
            r_cnt   <= '0;
            r_error <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: r_state <= S_SEND;
        S_SEND: begin
          r_pkt <= r_pkt >> 1;
          if (r_cnt == LastSend) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_ack) begin
            r_cnt   <= '0;
            r_state <= S_RECV;
          end else if (r_cnt == LastWait) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RECV: begin
          // Bits arrive LSB first; after R shifts the first bit sits in [0].
          r_result <= {spi.miso, r_result[REGISTER_SIZE-1:1]};
          if (r_cnt == LastRecv) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_error <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi.nss  = w_nss;
  assign spi.mosi = w_mosi;
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_error  = r_error;
  assign o_result = r_result;

endmodule

// File: tb/tb_mul_spi_master.sv
// Directed bench for mul_spi_master with a behavioural multiplier slave on nss[2].
module tb_mul_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_op_1, i_op_2;
  logic       o_busy, o_done, o_error;
  logic [7:0] o_result;

  int errors = 0;
  int checks = 0;
  int other_bad = 0;

  always #5 clk = ~clk;

  Spi #(.NssWidth(4)) spi_if ();

  mul_spi_master #(
    .REGISTER_SIZE(8), .NssWidth(4), .NssPosition(2), .TimeoutCycles(64)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_start (i_start),
    .i_op_1  (i_op_1),
    .i_op_2  (i_op_2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_error (o_error),
    .o_result(o_result),
    .spi     (spi_if)
  );

  // Slave: start flag, 16 packet bits, one operate cycle, ack, 8 product bits.
  logic [2:0]  sl_st;
  logic [3:0]  sl_cnt;
  logic [15:0] sl_pkt;
  logic [7:0]  sl_prod;
  logic        sl_mute;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_st <= 3'd0; sl_cnt <= 4'd0; sl_pkt <= 16'd0; sl_prod <= 8'd0;
    end else if (spi_if.nss[2]) begin
      sl_st <= 3'd0; sl_cnt <= 4'd0;
    end else begin
      case (sl_st)
        3'd0: if (spi_if.mosi) begin sl_st <= 3'd1; sl_cnt <= 4'd0; end
        3'd1: begin
          sl_pkt[sl_cnt] <= spi_if.mosi;
          sl_cnt <= sl_cnt + 4'd1;
          if (sl_cnt == 4'd15) sl_st <= 3'd2;
        end
        3'd2: begin
          sl_prod <= sl_pkt[7:0] * sl_pkt[15:8];
          sl_st   <= sl_mute ? 3'd5 : 3'd3;
        end
        3'd3: if (!spi_if.mosi) begin sl_st <= 3'd4; sl_cnt <= 4'd0; end
        3'd4: begin
          sl_cnt <= sl_cnt + 4'd1;
          if (sl_cnt == 4'd7) sl_st <= 3'd0;
        end
        default: sl_st <= sl_st;
      endcase
    end
  end

  assign spi_if.miso = (sl_st == 3'd3) ? 1'b1 :
                       (sl_st == 3'd4) ? sl_prod[sl_cnt[2:0]] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; cycle k is the k-th negedge after the accept edge.
  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input int pulse_k, input bit pulse_done,
                     output int done_cyc, output logic [15:0] pkt,
                     output logic first_mosi, output logic [7:0] res,
                     output logic err, output int nss_first, output int nss_last,
                     output logic post_busy, output logic post_err,
                     output logic [7:0] post_res);
    done_cyc = -1; nss_first = -1; nss_last = -1;
    pkt = '0; first_mosi = 1'b0; res = '0; err = 1'b0;
    @(negedge clk);
    i_op_1 = a; i_op_2 = b; i_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      i_start = (k == pulse_k);
      if (k == 2) begin i_op_1 = ~a; i_op_2 = ~b; end
      if (k == 1) first_mosi = spi_if.mosi;
      if (k >= 2 && k <= 17) pkt[k-2] = spi_if.mosi;
      if (!spi_if.nss[2]) begin
        if (nss_first < 0) nss_first = k;
        nss_last = k;
      end
      if ({spi_if.nss[3], spi_if.nss[1], spi_if.nss[0]} != 3'b111) other_bad++;
      if (o_done) begin
        done_cyc = k; res = o_result; err = o_error;
        if (pulse_done) i_start = 1'b1;
        break;
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    post_busy = o_busy; post_err = o_error; post_res = o_result;
  endtask

  int         dc, nf, nl, idle_hits;
  logic [15:0] pk;
  logic        fm, er, pb, pe;
  logic [7:0]  rs, pr;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_op_1 = '0; i_op_2 = '0; sl_mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_nss",    32'(spi_if.nss), 32'hF);
    chk("rst_mosi",   32'(spi_if.mosi), 32'd0);
    chk("rst_busy",   32'(o_busy), 32'd0);
    chk("rst_done",   32'(o_done), 32'd0);
    chk("rst_error",  32'(o_error), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 3 x 5
    txn(8'd3, 8'd5, -1, 1'b0, dc, pk, fm, rs, er, nf, nl, pb, pe, pr);
    chk("t1_start_flag", 32'(fm), 32'd1);
    chk("t1_packet",     32'(pk), 32'h0503);
    chk("t1_done_cyc",   32'(dc), 32'd28);
    chk("t1_result",     32'(rs), 32'd15);
    chk("t1_error",      32'(er), 32'd0);
    chk("t1_post_busy",  32'(pb), 32'd0);

    // T2: 0xFF x 0xFF truncates to 0x01
    txn(8'hFF, 8'hFF, -1, 1'b0, dc, pk, fm, rs, er, nf, nl, pb, pe, pr);
    chk("t2_packet",    32'(pk), 32'hFFFF);
    chk("t2_result",    32'(rs), 32'h01);
    chk("t2_nss_first", 32'(nf), 32'd1);
    chk("t2_nss_last",  32'(nl), 32'd27);
    chk("t2_done_cyc",  32'(dc), 32'd28);

    // T3: no ack -> timeout after 64 wait cycles starting at cycle 18
    sl_mute = 1'b1;
    txn(8'd4, 8'd4, -1, 1'b0, dc, pk, fm, rs, er, nf, nl, pb, pe, pr);
    sl_mute = 1'b0;
    chk("t3_done_cyc", 32'(dc), 32'd82);
    chk("t3_error",    32'(er), 32'd1);
    chk("t3_result",   32'(rs), 32'd0);
    chk("t3_nss_last", 32'(nl), 32'd81);
    chk("t3_err_clr",  32'(pe), 32'd0);
    chk("t3_post_res", 32'(pr), 32'd0);

    // T4: start pulses in SEND and DONE are ignored
    txn(8'd2, 8'd3, 5, 1'b1, dc, pk, fm, rs, er, nf, nl, pb, pe, pr);
    chk("t4_result",    32'(rs), 32'd6);
    chk("t4_done_cyc",  32'(dc), 32'd28);
    chk("t4_post_busy", 32'(pb), 32'd0);
    idle_hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy || o_done) idle_hits++;
    end
    chk("t4_no_requeue", 32'(idle_hits), 32'd0);
    txn(8'd12, 8'd11, -1, 1'b0, dc, pk, fm, rs, er, nf, nl, pb, pe, pr);
    chk("t4_next_result", 32'(rs), 32'h84);
    chk("t4_next_done",   32'(dc), 32'd28);

    // T5: reset during RECV bit 3 (cycle 23)
    @(negedge clk);
    i_op_1 = 8'd9; i_op_2 = 8'd9; i_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    chk("t5_busy_pre", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_nss",    32'(spi_if.nss), 32'hF);
    chk("t5_busy",   32'(o_busy), 32'd0);
    chk("t5_result", 32'(o_result), 32'd0);
    chk("t5_mosi",   32'(spi_if.mosi), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(8'd7, 8'd6, -1, 1'b0, dc, pk, fm, rs, er, nf, nl, pb, pe, pr);
    chk("t5_result_after", 32'(rs), 32'd42);
    chk("t5_done_cyc",     32'(dc), 32'd28);
    chk("t5_error",        32'(er), 32'd0);

    // T6: unselected nss lines never moved
    chk("t6_other_nss", 32'(other_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
